deal_controller: RTL
====================

# deal_controller

Baccarat round sequencer that sits directly downstream of the scoring stage. Each cycle it receives the player and banker hand scores, plus the raw rank of the player's third card. It drives the six card-register load strobes in the datapath and applies the player and banker third-card rules. When the round is decided, it latches the win lights.

## Interface
Parameters:
- HOLD_CYCLES, 8: cycles the DONE result is held before auto-restart (used only with DEAL_AUTO_RESTART_EN); legal range 1–255.

Ports:
- slow_clock  input  1  sole clock; all state changes on its rising edge.
- resetb  input  1  reset, synchronous, active-low.
- pscore  input  4  player hand score, 0–9, from the scoring stage.
- dscore  input  4  banker hand score, 0–9, from the scoring stage.
- pcard3  input  4  raw rank of the player's third card register; 0 = empty, 1–13 = A..K.
- clr_cards  output  1  datapath clears all six card registers to 0.
- load_pcard1, load_pcard2, load_pcard3  output  1 each  load the next dealt card into that player slot.
- load_dcard1, load_dcard2, load_dcard3  output  1 each  load the next dealt card into that banker slot.
- player_win_light, dealer_win_light  output  1 each  registered result lights.

## Operation
- Moore FSM. All load strobes and clr_cards are decoded from the current state. At most one of them is high in any cycle.
- States, with transitions:
  - IDLE: clr_cards=1. Next state DEAL_P1.
  - DEAL_P1: load_pcard1. Next state DEAL_D1.
  - DEAL_D1: load_dcard1. Next state DEAL_P2.
  - DEAL_P2: load_pcard2. Next state DEAL_D2.
  - DEAL_D2: load_dcard2. Next state EVAL.
  - EVAL: no strobes. The scores reflect all four cards at this point. Next state is chosen by the EVAL rules below.
  - P3: load_pcard3. Next state BANK_EVAL.
  - BANK_EVAL: no strobes. pcard3 and pscore now include the third card. Next state is chosen by the banker rules below.
  - D3: load_dcard3. Next state RESULT.
  - RESULT: no strobes. Lights are latched at this edge. Next state DONE.
  - DONE: no strobes. Lights held.
- EVAL rules:
  - If pscore ≥ 8 or dscore ≥ 8 (natural), go to RESULT.
  - Otherwise, if pscore ≤ 5, go to P3.
  - Otherwise (player stands on 6 or 7), go to D3 if dscore ≤ 5, else RESULT.
- Third-card value v = 0 if pcard3 ≥ 10, else pcard3.
- Banker rules in BANK_EVAL: the banker draws (go to D3) under the condition for its dscore below; otherwise go to RESULT.
  - dscore 0–2: always draws.
  - dscore 3: draws if v ≠ 8.
  - dscore 4: draws if v ∈ 2..7.
  - dscore 5: draws if v ∈ 4..7.
  - dscore 6: draws if v ∈ 6..7.
  - dscore 7: stands.
- Result, latched at the RESULT edge:
  - pscore > dscore: player_win_light=1.
  - dscore > pscore: dealer_win_light=1.
  - Equal scores (tie): both lights = 1.
- pscore and dscore values above 9 are treated as 9. No $error is raised.

## Timing
- While resetb=0 at an edge: state becomes IDLE and both lights go to 0. Reset values are: clr_cards=1, all six load strobes 0, both lights 0.
- Reset mid-round has priority over every transition. The round restarts from IDLE with the lights cleared.
- Each load strobe is high for exactly one cycle. The datapath captures the card at the end of that cycle. The scores are valid in the following cycle and are sampled there; they are never sampled in the same cycle as the strobe.
- Latency from the first cycle after reset release (IDLE) to DONE:
  - Natural: 7 cycles.
  - Player draw + banker draw: 10 cycles.
  - Player stands + banker draws: 8 cycles.
- Lights are 0 in every state except DONE. They become valid in the first DONE cycle.

## Configuration
- DEAL_AUTO_RESTART_EN undefined:
  - DONE is terminal until resetb is asserted.
  - No hold counter is synthesized.
- DEAL_AUTO_RESTART_EN defined:
  - An 8-bit counter clears on entry to DONE and increments each DONE cycle.
  - After HOLD_CYCLES DONE cycles the FSM moves to IDLE. The lights clear on that same edge and the next round begins.
  - Reset clears the counter.

## Test plan
The bench models the six card registers and the scoring stage, and feeds cards in deal order.

- Natural: P1=8, D1=2, P2=K, D2=3 (pscore 8, dscore 5) → EVAL→RESULT; load_pcard3 and load_dcard3 are never high; player_win_light=1 and dealer_win_light=0 in the 7th cycle after IDLE.
- Player draws, banker stands: P=2,3; D=3,4; P3=9 → player 4 vs banker 7; no load_dcard3; dealer_win_light=1.
- Banker on 3 with v=8: P=A,A; D=A,2; P3=8 → player 0, banker 3 stands; no load_dcard3; dealer_win_light=1.
- Player stands, banker draws, tie: P=6,10; D=4,A; D3=A → 6 vs 6; both lights = 1; no load_pcard3.
- Face third card: P=5,K; D=4,10; P3=Q (rank 12, v=0) → banker on 4 stands; player_win_light=1.
- Reset mid-round and restart:
  - resetb low for one edge while in DEAL_P2 → next cycle is IDLE with clr_cards=1 and the lights at 0; load_pcard1 follows one cycle later.
  - With DEAL_AUTO_RESTART_EN and HOLD_CYCLES=3: DONE lasts exactly 3 cycles, then IDLE with the lights at 0.

Source files
------------

// File: rtl/deal_controller.sv
// Baccarat round sequencer: deals four cards, applies the third-card rules, latches the win lights.
// Optional build macro DEAL_AUTO_RESTART_EN: restart the round after HOLD_CYCLES cycles in DONE.
`timescale 1ns/1ps
module deal_controller #(
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       clr_cards,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       player_win_light,
   output logic       dealer_win_light
);

   // state      | meaning
   // IDLE       | clear all card registers
   // DEAL_P1    | load player card 1
   // DEAL_D1    | load banker card 1
   // DEAL_P2    | load player card 2
   // DEAL_D2    | load banker card 2
   // EVAL       | naturals / player third-card decision
   // P3         | load player card 3
   // BANK_EVAL  | banker decision using the player's third card
   // D3         | load banker card 3
   // RESULT     | compare scores, lights latched on exit
   // DONE       | lights held
   typedef enum logic [3:0] {
      IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, P3, BANK_EVAL, D3, RESULT, DONE
   } state_t;

   state_t     state, state_nx;
   logic [3:0] ps, ds, v3;
   logic       banker_draw;
   logic       hold_done;
   logic [6:0] strobes;

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("HOLD_CYCLES must be in 1..255");
   end

   assign ps = (pscore > 4'd9) ? 4'd9 : pscore;
   assign ds = (dscore > 4'd9) ? 4'd9 : dscore;
   assign v3 = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

   always_comb begin
      banker_draw = 1'b0;
      case (ds)
         4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
         4'd3:             banker_draw = (v3 != 4'd8);
         4'd4:             banker_draw = (v3 >= 4'd2) && (v3 <= 4'd7);
         4'd5:             banker_draw = (v3 >= 4'd4) && (v3 <= 4'd7);
         4'd6:             banker_draw = (v3 >= 4'd6) && (v3 <= 4'd7);
         default:          banker_draw = 1'b0;
      endcase
   end

`ifdef DEAL_AUTO_RESTART_EN
   logic [7:0] hold_cnt;

   // Held at zero outside DONE so it starts from 0 on every entry.
   always_ff @(posedge slow_clock) begin
      if (!resetb)
         hold_cnt <= 8'd0;
      else if (state != DONE)
         hold_cnt <= 8'd0;
      else
         hold_cnt <= hold_cnt + 8'd1;
   end

   assign hold_done = (state == DONE) && (hold_cnt == 8'(HOLD_CYCLES - 1));
`else
   assign hold_done = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = DEAL_P1;
         DEAL_P1:   state_nx = DEAL_D1;
         DEAL_D1:   state_nx = DEAL_P2;
         DEAL_P2:   state_nx = DEAL_D2;
         DEAL_D2:   state_nx = EVAL;
         EVAL: begin
            if (ps >= 4'd8 || ds >= 4'd8)
               state_nx = RESULT;
            else if (ps <= 4'd5)
               state_nx = P3;
            else
               state_nx = (ds <= 4'd5) ? D3 : RESULT;
         end
         P3:        state_nx = BANK_EVAL;
         BANK_EVAL: state_nx = banker_draw ? D3 : RESULT;
         D3:        state_nx = RESULT;
         RESULT:    state_nx = DONE;
         DONE:      state_nx = hold_done ? IDLE : DONE;
         default:   state_nx = IDLE;
      endcase
   end

   // Strobe vector order: {clr, p1, d1, p2, d2, p3, d3}
   function automatic logic [6:0] decode(input state_t s);
      case (s)
         IDLE:    return 7'b1000000;
         DEAL_P1: return 7'b0100000;
         DEAL_D1: return 7'b0010000;
         DEAL_P2: return 7'b0001000;
         DEAL_D2: return 7'b0000100;
         P3:      return 7'b0000010;
         D3:      return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         state            <= IDLE;
         strobes          <= 7'b1000000;
         player_win_light <= 1'b0;
         dealer_win_light <= 1'b0;
      end else begin
         state   <= state_nx;
         strobes <= decode(state_nx);
         if (state == RESULT) begin
            player_win_light <= (ps >= ds);
            dealer_win_light <= (ds >= ps);
         end else if (state_nx == IDLE) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
         end
      end
   end

   assign {clr_cards, load_pcard1, load_dcard1, load_pcard2,
           load_dcard2, load_pcard3, load_dcard3} = strobes;

endmodule
